shift_rr_sched: RTL and testbench

//  Two-requester round-robin scheduler for the 8-bit logical left/right barrel shifter.
//  - Instantiates one shifter `shift` (d, s, c -> out); c=0 shifts left, c=1 shifts right.
//  - Arbitrates operand requests and sequences the shifter through a 3-state FSM.
//  - Returns each result on one registered response channel, tagged with the requester id.

---
 rtl/shift_rr_sched.sv | 173 +++++++++++++++++
 tb/tb_shift_rr_sched.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_rr_sched.sv
// Two-requester round-robin scheduler wrapped around an 8-bit logical barrel shifter.
// Optional feature: define SHIFT_SCHED_PERF_EN to add saturating per-requester
// grant counters (parameter CNT_W, ports cnt0/cnt1).

// Logical barrel shifter, zero fill: c=0 shifts left, c=1 shifts right.
module shift #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 3
) (
    input  logic [DW-1:0] d,
    input  logic [AW-1:0] s,
    input  logic          c,
    output logic [DW-1:0] out
);

    // Single-cycle combinational shift, result truncated to DW.
    always_comb begin
        out = c ? (d >> s) : (d << s);
    end

endmodule

module shift_rr_sched #(
    parameter int unsigned DW    = 8,
    parameter int unsigned AW    = 3
`ifdef SHIFT_SCHED_PERF_EN
    ,
    parameter int unsigned CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [DW-1:0]    req0_data,
    input  logic [AW-1:0]    req0_amt,
    input  logic             req0_dir,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [DW-1:0]    req1_data,
    input  logic [AW-1:0]    req1_amt,
    input  logic             req1_dir,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [DW-1:0]    rsp_data,
    output logic             rsp_id
`ifdef SHIFT_SCHED_PERF_EN
    ,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            last_grant;
    logic            grant_id;
    logic            accept;
    logic [DW-1:0]   op_data;
    logic [AW-1:0]   op_amt;
    logic            op_dir;
    logic            op_id;
    logic [DW-1:0]   shift_out;

    shift #(
        .DW (DW),
        .AW (AW)
    ) u_shift (
        .d   (op_data),
        .s   (op_amt),
        .c   (op_dir),
        .out (shift_out)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, round-robin grant and same-cycle readies (only in IDLE).
    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        grant_id   = 1'b0;
        case (state)
            IDLE: begin
                if (req0_valid && req1_valid) begin
                    grant_id = ~last_grant;
                end else begin
                    grant_id = req1_valid;
                end
                if (!rst) begin
                    req0_ready = req0_valid && !grant_id;
                    req1_ready = req1_valid && grant_id;
                end
                if (req0_ready || req1_ready) begin
                    state_nxt = CALC;
                end
            end
            CALC: begin
                state_nxt = RESP;
            end
            RESP: begin
                if (rsp_valid && rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign accept = req0_ready | req1_ready;

    // Operand capture on handshake, result register, response channel.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_data    <= '0;
            op_amt     <= '0;
            op_dir     <= 1'b0;
            op_id      <= 1'b0;
            last_grant <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_id     <= 1'b0;
        end else begin
            if (accept) begin
                op_data    <= grant_id ? req1_data : req0_data;
                op_amt     <= grant_id ? req1_amt  : req0_amt;
                op_dir     <= grant_id ? req1_dir  : req0_dir;
                op_id      <= grant_id;
                last_grant <= grant_id;
            end
            if (state == CALC) begin
                rsp_data  <= shift_out;
                rsp_id    <= op_id;
                rsp_valid <= 1'b1;
            end else if (state == RESP && rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

`ifdef SHIFT_SCHED_PERF_EN
    // Saturating count of accepted handshakes per requester.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (req0_ready && cnt0 != '1) begin
                cnt0 <= cnt0 + CNT_W'(1);
            end
            if (req1_ready && cnt1 != '1) begin
                cnt1 <= cnt1 + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_shift_rr_sched.sv
// Directed self-checking bench for shift_rr_sched.
// With SHIFT_SCHED_PERF_EN defined the counters are built with CNT_W=2.
module tb_shift_rr_sched;

    logic       clk;
    logic       rst;
    logic       req0_valid, req0_ready, req0_dir;
    logic [7:0] req0_data;
    logic [2:0] req0_amt;
    logic       req1_valid, req1_ready, req1_dir;
    logic [7:0] req1_data;
    logic [2:0] req1_amt;
    logic       rsp_valid, rsp_ready, rsp_id;
    logic [7:0] rsp_data;
`ifdef SHIFT_SCHED_PERF_EN
    logic [1:0] cnt0, cnt1;
`endif

    int checks   = 0;
    int failures = 0;

`ifdef SHIFT_SCHED_PERF_EN
    shift_rr_sched #(.DW(8), .AW(3), .CNT_W(2)) dut (
`else
    shift_rr_sched #(.DW(8), .AW(3)) dut (
`endif
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_data  (req0_data),
        .req0_amt   (req0_amt),
        .req0_dir   (req0_dir),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_data  (req1_data),
        .req1_amt   (req1_amt),
        .req1_dir   (req1_dir),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id)
`ifdef SHIFT_SCHED_PERF_EN
        ,
        .cnt0       (cnt0),
        .cnt1       (cnt1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report a mismatch.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Drive one requester's operand set.
    task automatic drive(input logic id, input logic v, input logic [7:0] d,
                         input logic [2:0] a, input logic dr);
        if (id) begin
            req1_valid = v; req1_data = d; req1_amt = a; req1_dir = dr;
        end else begin
            req0_valid = v; req0_data = d; req0_amt = a; req0_dir = dr;
        end
    endtask

    // Reset for two cycles and check that every output reads zero.
    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 3'd0, 1'b0);
        drive(1'b1, 1'b0, 8'h00, 3'd0, 1'b0);
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_data"},  32'(rsp_data),  32'd0);
        check({tag, "_rsp_id"},    32'(rsp_id),    32'd0);
        check({tag, "_readies"},   32'({req1_ready, req0_ready}), 32'd0);
`ifdef SHIFT_SCHED_PERF_EN
        check({tag, "_cnt"}, 32'({cnt1, cnt0}), 32'd0);
`endif
        rst = 1'b0;
    endtask

    // Wait (bounded) for requester id's ready; returns 1 if seen.
    task automatic wait_ready(input logic id, input string tag, output bit ok);
        int n = 0;
        while (!(id ? req1_ready : req0_ready) && n < 20) begin
            @(negedge clk); #1; n++;
        end
        ok = id ? req1_ready : req0_ready;
        check({tag, "_ready"}, 32'(ok), 32'd1);
    endtask

    // One isolated operation with rsp_ready=1: checks 2-cycle latency, data and id.
    task automatic run_op(input string tag, input logic id, input logic [7:0] d,
                          input logic [2:0] a, input logic dr, input logic [7:0] exp);
        bit ok;
        @(negedge clk);
        drive(id, 1'b1, d, a, dr);
        #1;
        wait_ready(id, tag, ok);
        check({tag, "_other_ready"}, 32'(id ? req0_ready : req1_ready), 32'd0);
        @(negedge clk);
        drive(id, 1'b0, 8'h00, 3'd0, 1'b0);
        #1;
        check({tag, "_lat1"}, 32'(rsp_valid), 32'd0);
        @(negedge clk); #1;
        check({tag, "_lat2"}, 32'(rsp_valid), 32'd1);
        check({tag, "_data"}, 32'(rsp_data),  32'(exp));
        check({tag, "_id"},   32'(rsp_id),    32'(id));
    endtask

    initial begin
        bit ok;
        rst = 1'b1;
        rsp_ready = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 3'd0, 1'b0);
        drive(1'b1, 1'b0, 8'h00, 3'd0, 1'b0);
        do_reset("rst0");

        // Basic ops and arithmetic boundaries.
        run_op("t1_b1_l3",  1'b0, 8'hB1, 3'd3, 1'b0, 8'h88);
        run_op("t2_f0_r4",  1'b1, 8'hF0, 3'd4, 1'b1, 8'h0F);
        run_op("t2_80_r7",  1'b1, 8'h80, 3'd7, 1'b1, 8'h01);
        run_op("t2_5a_l0",  1'b0, 8'h5A, 3'd0, 1'b0, 8'h5A);
        run_op("t2_a5_r0",  1'b1, 8'hA5, 3'd0, 1'b1, 8'hA5);
        run_op("t2_ff_l7",  1'b0, 8'hFF, 3'd7, 1'b0, 8'h80);

        // Continuous contention from reset: grants alternate starting with req0.
        do_reset("rst1");
        @(negedge clk);
        drive(1'b0, 1'b1, 8'h0F, 3'd1, 1'b0);
        drive(1'b1, 1'b1, 8'hF0, 3'd1, 1'b1);
        #1;
        for (int i = 0; i < 4; i++) begin
            int n = 0;
            while (!(req0_ready || req1_ready) && n < 20) begin
                @(negedge clk); #1; n++;
            end
            check($sformatf("t3_both_ready_%0d", i), 32'(req0_ready && req1_ready), 32'd0);
            check($sformatf("t3_grant_%0d", i), 32'({req1_ready, req0_ready}),
                  (i % 2 == 0) ? 32'd1 : 32'd2);
            @(negedge clk); @(negedge clk); #1;
            check($sformatf("t3_rsp_valid_%0d", i), 32'(rsp_valid), 32'd1);
            check($sformatf("t3_rsp_id_%0d", i), 32'(rsp_id), 32'(i % 2));
            check($sformatf("t3_rsp_data_%0d", i), 32'(rsp_data),
                  (i % 2 == 0) ? 32'h1E : 32'h78);
            check($sformatf("t3_ready_busy_%0d", i), 32'({req1_ready, req0_ready}), 32'd0);
            @(negedge clk); #1;
        end

        // Consumer stall: response held five cycles, readies low, accept on sixth.
        do_reset("rst2");
        rsp_ready = 1'b0;
        @(negedge clk);
        drive(1'b0, 1'b1, 8'h33, 3'd2, 1'b0);
        #1;
        wait_ready(1'b0, "t4", ok);
        @(negedge clk);
        drive(1'b0, 1'b0, 8'h00, 3'd0, 1'b0);
        drive(1'b1, 1'b1, 8'h01, 3'd1, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("t4_hold_valid_%0d", i), 32'(rsp_valid), 32'd1);
            check($sformatf("t4_hold_data_%0d", i), 32'(rsp_data), 32'hCC);
            check($sformatf("t4_hold_id_%0d", i), 32'(rsp_id), 32'd0);
            check($sformatf("t4_hold_ready_%0d", i), 32'({req1_ready, req0_ready}), 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        check("t4_still_valid", 32'(rsp_valid), 32'd1);
        @(negedge clk); #1;
        check("t4_released", 32'(rsp_valid), 32'd0);
        check("t4_req1_ready", 32'(req1_ready), 32'd1);
        @(negedge clk);
        drive(1'b1, 1'b0, 8'h00, 3'd0, 1'b0);
        @(negedge clk); #1;
        check("t4_next_valid", 32'(rsp_valid), 32'd1);
        check("t4_next_data", 32'(rsp_data), 32'h02);
        check("t4_next_id", 32'(rsp_id), 32'd1);

        // Reset during CALC drops the op; the next request is served normally.
        @(negedge clk);
        drive(1'b0, 1'b1, 8'h11, 3'd1, 1'b0);
        #1;
        wait_ready(1'b0, "t5", ok);
        @(negedge clk);
        drive(1'b0, 1'b0, 8'h00, 3'd0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t5_rsp_valid", 32'(rsp_valid), 32'd0);
        check("t5_rsp_data", 32'(rsp_data), 32'd0);
        check("t5_rsp_id", 32'(rsp_id), 32'd0);
        repeat (3) @(negedge clk);
        #1;
        check("t5_no_rsp", 32'(rsp_valid), 32'd0);
        run_op("t5_after", 1'b1, 8'h81, 3'd1, 1'b1, 8'h40);

`ifdef SHIFT_SCHED_PERF_EN
        // Saturating grant counters with CNT_W=2.
        do_reset("rst3");
        for (int i = 0; i < 3; i++) run_op($sformatf("t6_r0_%0d", i), 1'b0, 8'h01, 3'd1, 1'b0, 8'h02);
        for (int i = 0; i < 2; i++) run_op($sformatf("t6_r1_%0d", i), 1'b1, 8'h80, 3'd1, 1'b1, 8'h40);
        check("t6_cnt0", 32'(cnt0), 32'd3);
        check("t6_cnt1", 32'(cnt1), 32'd2);
        run_op("t6_r0_sat", 1'b0, 8'h01, 3'd1, 1'b0, 8'h02);
        check("t6_cnt0_sat", 32'(cnt0), 32'd3);
        check("t6_cnt1_keep", 32'(cnt1), 32'd2);
`endif

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
